// File: rtl/datamem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port 0 is the MEM stage; port 1 is the loader/debug requester.
package datamem_arb_pkg;

    localparam int STARVE_W = 8;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE
    } arb_state_t;

endpackage

// File: rtl/datamem_arb_starve.sv
// Saturating count of consecutive cycles in which port 1 asked for the memory and was refused.
module datamem_arb_starve
    import datamem_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic [STARVE_W-1:0] count,
    output logic                at_limit
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != limit)) begin
            count <= count + STARVE_W'(1);
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/datamem_arbiter.sv
// Fixed-priority two-port arbiter in front of datamem, with starvation relief for port 1
// and a one-cycle registered read-return path.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_stall,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_MemWrite,
    output logic          mem_MemRead,
    output logic [AW-1:0] mem_Addr,
    output logic [DW-1:0] mem_Wdata,
    input  logic [DW-1:0] mem_Rdata
);

    localparam logic [STARVE_W-1:0] LIMIT    = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] LIMIT_M1 = STARVE_W'(STARVE_MAX - 1);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic                at_limit;
    logic                force_p1;
    logic                p1_denied;
    logic                winner;
    logic                rd_pending;
    logic                rd_owner;

    // Grants are gated by rst so nothing reaches the memory while the block is held in reset.
    assign force_p1  = (state_q == ARB_FORCE) && p1_req;
    assign p0_gnt    = !rst && p0_req && !force_p1;
    assign p1_gnt    = !rst && p1_req && (force_p1 || !p0_req);
    assign p0_stall  = !rst && p0_req && !p0_gnt;
    assign p1_denied = p1_req && !p1_gnt;

    assign winner       = p1_gnt ? ARB_P1 : ARB_P0;
    assign mem_Addr     = (winner == ARB_P1) ? p1_addr  : p0_addr;
    assign mem_Wdata    = (winner == ARB_P1) ? p1_wdata : p0_wdata;
    assign mem_MemWrite = (p0_gnt && p0_we)  || (p1_gnt && p1_we);
    assign mem_MemRead  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);

    datamem_arb_starve u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (p1_denied),
        .clr      (!p1_denied),
        .limit    (LIMIT),
        .count    (starve_cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // FORCE is entered on the same edge at which the counter reaches its limit.
    // NOTE: state_d is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_NORMAL: if (p1_denied && (starve_cnt == LIMIT_M1)) state_d = ARB_FORCE;
            ARB_FORCE:  if (p1_gnt || !p1_req)                     state_d = ARB_NORMAL;
            default:    state_d = ARB_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            rd_owner   <= ARB_P0;
        end else begin
            rd_pending <= mem_MemRead;
            if (mem_MemRead) begin
                rd_owner <= winner;
            end
        end
    end

    // rst also masks the return combinationally, so a read granted just before reset never completes.
    assign p0_rvalid = !rst && rd_pending && (rd_owner == ARB_P0);
    assign p1_rvalid = !rst && rd_pending && (rd_owner == ARB_P1);
    assign p0_rdata  = p0_rvalid ? mem_Rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_Rdata : '0;

    property p_force_tracks_limit;
        @(posedge clk) disable iff (rst) (state_q == ARB_FORCE) == at_limit;
    endproperty
    a_force_tracks_limit: assert property (p_force_tracks_limit);

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter that shares the single data memory (`datamem`) between the pipeline MEM stage (port 0) and a memory loader/debug requester (port 1). Port 0 has fixed priority; port 1 is guaranteed one access after `STARVE_MAX` consecutive denied cycles. The block drives the memory's `MemWrite`/`MemRead`/`Addr`/`Wdata` strobes, returns read data with a registered valid, and produces the MEM-stage stall. It sits between the MEM-stage pipeline register and `datamem`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive port-1 denials before port 1 is forced; legal range 1..255

- `clk`  in  1  rising-edge clock, shared with `datamem`
- `rst`  in  1  synchronous, active-high reset
- `p0_req` / `p1_req`  in  1  access request; must stay high with payload stable until `pN_gnt`
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read
- `p0_addr` / `p1_addr`  in  AW  word address
- `p0_wdata` / `p1_wdata`  in  DW  write data
- `p0_gnt` / `p1_gnt`  out  1  combinational grant; access occurs at the next `clk` edge
- `p0_rvalid` / `p1_rvalid`  out  1  read data valid, registered
- `p0_rdata` / `p1_rdata`  out  DW  read data, meaningful only while `pN_rvalid`
- `p0_stall`  out  1  `p0_req & ~p0_gnt`; freezes the MEM stage
- `mem_MemWrite`, `mem_MemRead`  out  1  memory strobes
- `mem_Addr`  out  AW
- `mem_Wdata`  out  DW
- `mem_Rdata`  in  DW  memory read data, registered inside memory

## Operation
- Grant, combinational:
  - Forced when `starve_cnt == STARVE_MAX` and `p1_req`: `p1_gnt=1`, `p0_gnt=0`.
  - Otherwise `p0_gnt = p0_req`, `p1_gnt = p1_req & ~p0_req`.
- At most one grant per cycle.
- Memory drive:
  - Winner's address and wdata are muxed to `mem_*`.
  - `mem_MemWrite = gnt & we`; `mem_MemRead = gnt & ~we`.
  - No grant: both strobes 0; addr/wdata hold the port-0 value.
- Starvation counter `starve_cnt`, 8 bits, registered:
  - Increments when `p1_req & ~p1_gnt`.
  - Clears when `p1_gnt` or `~p1_req`.
  - Saturates at `STARVE_MAX`.
- Read return:
  - Registers `rd_owner` and `rd_pending` on each granted read.
  - Next cycle, `pN_rvalid=1` for the owner and `pN_rdata = mem_Rdata`; the other port's rdata is 0.
- Writes produce no response.
- Arbiter state enum `{ARB_NORMAL, ARB_FORCE}`:
  - `ARB_FORCE` when `starve_cnt == STARVE_MAX`.
  - Returns to `ARB_NORMAL` after the forced grant, or when `p1_req` drops.

## Timing
- While `rst` is high, all grants, strobes, `rvalid` and `p0_stall` are 0, regardless of requests.
- Reset values: `starve_cnt=0`, state `ARB_NORMAL`, `rd_pending=0`, all rdata 0.
- Grant-to-access latency: 0 cycles; the memory samples at the same edge the grant is seen.
- Read latency: `rvalid` exactly 1 cycle after the granted cycle; single-cycle pulse per read.
- Back-to-back reads from alternating ports: each `rvalid` pulses on its own port, 1 cycle after its own grant; no bubbles.
- Write then read of the same address in consecutive cycles returns the new data.
- Reset asserted the cycle after a granted read: `rvalid` is suppressed.
- A request dropped without a grant is legal and produces no access.
- With `STARVE_MAX=1`, port 1 is granted every second cycle under continuous port-0 load.

## Structure
- Shared package `datamem_arb_pkg`:
  - `arb_state_t` enum.
  - Port index constants `ARB_P0=1'b0`, `ARB_P1=1'b1`.
  - `STARVE_W=8`.
- Sub-module `datamem_arb_starve`: saturating starvation counter with `inc`, `clr`, `limit` inputs and `at_limit` output.
- Everything else (grant logic, mux, read-return register) lives in the top module.

## Test plan
- Reset with both `req=1` -> no grants, strobes 0, `p0_stall=0`. After release, `p0_gnt=1` in the same cycle.
- Port 0 writes 0xDEADBEEF to 0x00100002, then reads it next cycle -> `p0_rvalid` one cycle later with `p0_rdata=0xDEADBEEF`; `p1_rvalid` stays 0.
- `p1_req` held high under continuous `p0_req`, `STARVE_MAX=4` -> `p1_gnt` on the 5th cycle. On that cycle `p0_stall=1`, then `starve_cnt` returns to 0.
- Port-1 read of 0x00100001 while port 0 is idle -> immediate `p1_gnt`. `p1_rvalid` next cycle with the memory contents; `p0_rdata=0`.
- `p1_req` dropped after 3 denials, then reasserted -> counter restarts; forced grant comes 4 denials later, not 1.
- Granted port-0 read followed by `rst=1` -> `p0_rvalid` stays 0, and state and counter reset.
